vec_rewind_fifo: RTL and testbench
==================================

VEC_REWIND_FIFO -- requirements
Module: vec_rewind_fifo

Interface
REQ-001 SHALL have parameter NBits, default 8, bits per element.
REQ-002 SHALL have parameter VecElements, default 8, elements per vector; SHALL be divisible by WrElems and RdElems.
REQ-003 SHALL have parameter WrElems, default 4, elements per write beat.
REQ-004 SHALL have parameter RdElems, default 2, elements per read beat.
REQ-005 SHALL have parameter Depth, default 2, vectors of storage; N = Depth*VecElements SHALL be a power of two.
REQ-006 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst_in  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port clear  input  1  synchronous flush.
REQ-009 SHALL have ports s_valid input 1, s_ready output 1, s_data input [WrElems-1:0][NBits-1:0]: write handshake; lane 0 is the oldest element.
REQ-010 SHALL have ports m_valid output 1, m_ready input 1, m_data output [RdElems-1:0][NBits-1:0]: read handshake; lane 0 is the oldest element.
REQ-011 SHALL have port rd_repeat  input  1  sampled on the last read beat of a vector; replays that vector.
REQ-012 SHALL have port vec_done  output  1  one-cycle pulse when a vector is released.
REQ-013 SHALL have port fill_count  output  $clog2(N)+1  elements held, unreleased.

Function
REQ-014 Write SHALL occur on an edge with s_valid&&s_ready; WrElems elements stored at wr_ptr; wr_ptr += WrElems modulo N.
REQ-015 s_ready SHALL equal (N - fill_count) >= WrElems, combinational from registered state only.
REQ-016 Read SHALL occur on an edge with m_valid&&m_ready; rd_ptr += RdElems modulo N.
REQ-017 m_valid SHALL equal (elements written minus elements read since vec_base) >= RdElems; m_data SHALL be elements rd_ptr..rd_ptr+RdElems-1, combinational from storage.
REQ-018 Data written on edge k SHALL be readable in the cycle after edge k; no further latency.
REQ-019 vec_base SHALL mark the first element of the vector being read; beat index counts 0..VecElements/RdElems-1.
REQ-020 On a read of the final beat with rd_repeat=0: vec_base and rd_ptr SHALL advance to vec_base+VecElements; fill_count -= VecElements; vec_done=1 next cycle.
REQ-021 On a read of the final beat with rd_repeat=1: rd_ptr SHALL return to vec_base; fill_count unchanged; vec_done stays 0; beat index resets to 0.
REQ-022 rd_repeat SHALL be ignored on non-final beats.
REQ-023 Elements SHALL NOT be overwritten before release; space is freed only by REQ-020.
REQ-024 Simultaneous write and release SHALL update fill_count by +WrElems-VecElements in one edge; s_ready at full SHALL rise the cycle after release.
REQ-025 Pointers SHALL wrap modulo N with no bubble; ordering SHALL be preserved across wrap.
REQ-026 clear=1 SHALL zero wr_ptr, rd_ptr, vec_base, beat index, fill_count, vec_done on the next edge, taking precedence over any concurrent handshake.
REQ-027 Storage contents SHALL NOT require reset or clear.

Reset
REQ-028 rst_in low SHALL immediately force wr_ptr, rd_ptr, vec_base, beat index, fill_count to 0, vec_done=0, m_valid=0, s_ready=1.
REQ-029 Reset asserted mid-transfer SHALL discard all held data; first write after release of rst_in starts at element 0.

Verification (defaults, N=16)
REQ-030 Reset, write 4 beats of elements 0..15 -> s_ready=0 after 4th write, fill_count=16; 4 reads return {0,1},{2,3},{4,5},{6,7}; vec_done pulses once; fill_count=8; s_ready=1.
REQ-031 Write 0..7, read 4 beats with rd_repeat=1 on 4th -> next m_data={0,1}, fill_count=8, no vec_done; read 4 beats with rd_repeat=0 -> vec_done pulses, fill_count=0, m_valid=0.
REQ-032 Full FIFO (fill_count=16), final-beat read and s_valid held -> write stalls until the cycle after release, then accepted; fill_count 16 -> 8 -> 12.
REQ-033 Stream 48 elements with continuous s_valid/m_ready -> read order exactly 0..47 across three pointer wraps; no lost or duplicated element.
REQ-034 rst_in low mid-vector -> m_valid=0, fill_count=0 in the same cycle; clear=1 together with s_valid&&s_ready -> write dropped, fill_count=0.

Source files
------------

// File: rtl/vec_rewind_fifo.sv
// Vector FIFO: WrElems-wide writes, RdElems-wide reads, released a whole vector at a time.
// Latency: a write on edge k is readable in the cycle after edge k; read data is combinational from storage.
// Backpressure: s_ready drops when fewer than WrElems free slots remain; space returns only when a vector is released.
module vec_rewind_fifo #(
  parameter int NBits       = 8,
  parameter int VecElements = 8,
  parameter int WrElems     = 4,
  parameter int RdElems     = 2,
  parameter int Depth       = 2
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic                                    clear,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [WrElems-1:0][NBits-1:0]           s_data,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [RdElems-1:0][NBits-1:0]           m_data,
  input  logic                                    rd_repeat,
  output logic                                    vec_done,
  output logic [$clog2(Depth*VecElements):0]      fill_count
);

  localparam int N     = Depth * VecElements;
  localparam int PW    = $clog2(N);
  localparam int CW    = PW + 1;
  localparam int Beats = VecElements / RdElems;
  localparam int BW    = (Beats > 1) ? $clog2(Beats) : 1;

  localparam logic [CW-1:0] NCnt   = CW'(N);
  localparam logic [CW-1:0] WrCnt  = CW'(WrElems);
  localparam logic [CW-1:0] RdCnt  = CW'(RdElems);
  localparam logic [CW-1:0] VecCnt = CW'(VecElements);
  localparam logic [PW-1:0] WrStep  = PW'(WrElems);
  localparam logic [PW-1:0] RdStep  = PW'(RdElems);
  localparam logic [PW-1:0] VecStep = PW'(VecElements);
  localparam logic [BW-1:0] LastBeat = BW'(Beats - 1);

  // Storage is never reset; occupancy is tracked purely by the pointers and fill count.
  logic [NBits-1:0] mem_q [N];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] base_q, base_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          done_q, done_d;

  logic [CW-1:0] rd_off;
  logic          wr_fire;
  logic          rd_fire;
  logic          last_beat;
  logic          release_vec;
  logic          rewind_vec;

  // fill_q counts every element not yet released, so the elements already
  // consumed from the current vector must be subtracted before judging m_valid.
  assign rd_off      = CW'(beat_q) * RdCnt;
  assign s_ready     = (NCnt - fill_q) >= WrCnt;
  assign m_valid     = (fill_q - rd_off) >= RdCnt;
  assign wr_fire     = s_valid && s_ready;
  assign rd_fire     = m_valid && m_ready;
  assign last_beat   = (beat_q == LastBeat);
  assign release_vec = rd_fire && last_beat && !rd_repeat;
  assign rewind_vec  = rd_fire && last_beat && rd_repeat;

  assign vec_done   = done_q;
  assign fill_count = fill_q;

  // Next-state for pointers, beat index and occupancy; clear overrides any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    base_d   = base_q;
    beat_d   = beat_q;
    fill_d   = fill_q;
    done_d   = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      base_d   = '0;
      beat_d   = '0;
      fill_d   = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + WrStep;
      end
      if (release_vec) begin
        base_d   = base_q + VecStep;
        rd_ptr_d = base_q + VecStep;
        beat_d   = '0;
      end else if (rewind_vec) begin
        rd_ptr_d = base_q;
        beat_d   = '0;
      end else if (rd_fire) begin
        rd_ptr_d = rd_ptr_q + RdStep;
        beat_d   = beat_q + BW'(1);
      end
      fill_d = fill_q + (wr_fire ? WrCnt : '0) - (release_vec ? VecCnt : '0);
      done_d = release_vec;
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      base_q   <= '0;
      beat_q   <= '0;
      fill_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      fill_q   <= fill_d;
      done_q   <= done_d;
    end
  end

  // Store an accepted write beat; lane 0 lands at the lowest (oldest) address.
  always_ff @(posedge clk_in) begin
    if (wr_fire && !clear) begin
      for (int i = 0; i < WrElems; i++) begin
        mem_q[wr_ptr_q + PW'(i)] <= s_data[i];
      end
    end
  end

  // Present the current read beat straight from storage, wrapping modulo N.
  always_comb begin
    m_data = '0;
    for (int i = 0; i < RdElems; i++) begin
      m_data[i] = mem_q[rd_ptr_q + PW'(i)];
    end
  end

endmodule

// File: tb/tb_vec_rewind_fifo.sv
// Bench for vec_rewind_fifo with default parameters (N=16, 4-wide write, 2-wide read, 8-element vector).
// A queue model of held elements predicts every output each cycle; a vector table drives the basic sequences.
// Multi-cycle corners (full-stall release, streaming wrap, async reset, clear) are hand-written sequences.
module tb_vec_rewind_fifo;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             clear;
  logic             s_valid;
  logic             s_ready;
  logic [3:0][7:0]  s_data;
  logic             m_valid;
  logic             m_ready;
  logic [1:0][7:0]  m_data;
  logic             rd_repeat;
  logic             vec_done;
  logic [4:0]       fill_count;

  vec_rewind_fifo dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clear      (clear),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .rd_repeat  (rd_repeat),
    .vec_done   (vec_done),
    .fill_count (fill_count)
  );

  always #5 clk_in = ~clk_in;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model: elements written but not released, oldest first, plus the read beat index.
  int mq[$];
  int mbeat  = 0;
  bit mdone  = 1'b0;
  bit last_wr;
  bit last_rd;
  int nreads = 0;

  typedef struct {
    bit sv;
    int base;
    bit mr;
    bit rep;
    int fill;
    bit sr;
    bit mv;
    bit vd;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input bit sv, input int base, input bit mr, input bit rep, input bit clr);
    s_valid   = sv;
    for (int i = 0; i < 4; i++) s_data[i] = 8'(base + i);
    m_ready   = mr;
    rd_repeat = rep;
    clear     = clr;
  endtask

  // One clock: check pre-edge outputs against the model, advance the model, check post-edge outputs.
  task automatic cyc(input string tag);
    bit esr, emv, rep_s, clr_s;
    int hold;
    int wv[4];
    #1;
    hold = mq.size();
    esr  = (16 - hold) >= 4;
    emv  = (hold - mbeat * 2) >= 2;
    chk({tag, ":s_ready"}, int'(s_ready), int'(esr));
    chk({tag, ":m_valid"}, int'(m_valid), int'(emv));
    if (emv) begin
      for (int i = 0; i < 2; i++)
        chk($sformatf("%s:m_data[%0d]", tag, i), int'(m_data[i]), mq[mbeat * 2 + i]);
    end
    last_wr = s_valid && esr && !clear;
    last_rd = m_ready && emv && !clear;
    rep_s   = rd_repeat;
    clr_s   = clear;
    for (int i = 0; i < 4; i++) wv[i] = int'(s_data[i]);
    @(posedge clk_in);
    mdone = 1'b0;
    if (clr_s) begin
      mq.delete();
      mbeat = 0;
    end else begin
      if (last_rd) begin
        nreads += 2;
        if (mbeat == 3) begin
          if (!rep_s) begin
            for (int i = 0; i < 8; i++) void'(mq.pop_front());
            mdone = 1'b1;
          end
          mbeat = 0;
        end else begin
          mbeat++;
        end
      end
      if (last_wr) for (int i = 0; i < 4; i++) mq.push_back(wv[i]);
    end
    #1;
    chk({tag, ":fill_count"}, int'(fill_count), mq.size());
    chk({tag, ":vec_done"}, int'(vec_done), int'(mdone));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int wcnt;

    // s_valid, base, m_ready, rd_repeat | fill, s_ready, m_valid, vec_done (after the edge)
    tbl[0]  = '{1'b1,  0, 1'b0, 1'b0,  4, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1,  4, 1'b0, 1'b0,  8, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1,  8, 1'b0, 1'b0, 12, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 12, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0,  0, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0,  0, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0,  0, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0,  0, 1'b1, 1'b0,  8, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0,  0, 1'b0, 1'b0,  8, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0,  0, 1'b1, 1'b0,  8, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0,  0, 1'b1, 1'b0,  8, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0,  0, 1'b1, 1'b0,  8, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0,  0, 1'b1, 1'b0,  0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0,  0, 1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1,  0, 1'b0, 1'b0,  4, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b1,  4, 1'b0, 1'b0,  8, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0,  0, 1'b1, 1'b1,  8, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b0,  0, 1'b1, 1'b0,  8, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b0,  0, 1'b1, 1'b0,  8, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{1'b0,  0, 1'b1, 1'b1,  8, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1'b0,  0, 1'b1, 1'b0,  8, 1'b1, 1'b1, 1'b0};
    tbl[21] = '{1'b0,  0, 1'b1, 1'b0,  8, 1'b1, 1'b1, 1'b0};
    tbl[22] = '{1'b0,  0, 1'b1, 1'b0,  8, 1'b1, 1'b1, 1'b0};
    tbl[23] = '{1'b0,  0, 1'b1, 1'b0,  0, 1'b1, 1'b0, 1'b1};
    tbl[24] = '{1'b0,  0, 1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b0};

    rst_in = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("reset:s_ready", int'(s_ready), 1);
    chk("reset:m_valid", int'(m_valid), 0);
    chk("reset:fill_count", int'(fill_count), 0);
    chk("reset:vec_done", int'(vec_done), 0);
    #11 rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Basic fill/drain, release, rd_repeat ignored on a non-final beat, rewind.
    for (int r = 0; r < 25; r++) begin
      drive(tbl[r].sv, tbl[r].base, tbl[r].mr, tbl[r].rep, 1'b0);
      cyc($sformatf("row%0d", r));
      chk($sformatf("row%0d:tbl_fill", r), int'(fill_count), tbl[r].fill);
      chk($sformatf("row%0d:tbl_s_ready", r), int'(s_ready), int'(tbl[r].sr));
      chk($sformatf("row%0d:tbl_m_valid", r), int'(m_valid), int'(tbl[r].mv));
      chk($sformatf("row%0d:tbl_vec_done", r), int'(vec_done), int'(tbl[r].vd));
      if (r == 7) begin
        chk("after_release:m_data[0]", int'(m_data[0]), 8);
        chk("after_release:m_data[1]", int'(m_data[1]), 9);
      end
      if (r == 19) begin
        chk("after_rewind:m_data[0]", int'(m_data[0]), 0);
        chk("after_rewind:m_data[1]", int'(m_data[1]), 1);
      end
    end

    // Full FIFO: a write held against a final-beat release is accepted only the cycle after.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 100 + 4 * i, 1'b0, 1'b0, 1'b0);
      cyc("full_fill");
    end
    chk("full:fill16", int'(fill_count), 16);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cyc("full_read");
    end
    drive(1'b1, 120, 1'b1, 1'b0, 1'b0);
    cyc("full_release");
    chk("full:fill_after_release", int'(fill_count), 8);
    chk("full:s_ready_after_release", int'(s_ready), 1);
    drive(1'b1, 120, 1'b0, 1'b0, 1'b0);
    cyc("full_accept");
    chk("full:fill_after_accept", int'(fill_count), 12);
    drive(1'b1, 124, 1'b0, 1'b0, 1'b0);
    cyc("full_complete");
    n = 0;
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    while (mq.size() > 0 && n < 40) begin
      cyc("full_drain");
      n++;
    end
    chk("full:drained", int'(fill_count), 0);

    // Continuous streaming across several pointer wraps.
    wcnt   = 0;
    nreads = 0;
    n      = 0;
    while (n < 200 && !(wcnt == 48 && mq.size() == 0)) begin
      drive(wcnt < 48, wcnt, 1'b1, 1'b0, 1'b0);
      cyc("stream");
      if (last_wr) wcnt += 4;
      n++;
    end
    chk("stream:elements_read", nreads, 48);
    chk("stream:elements_written", wcnt, 48);
    chk("stream:final_fill", int'(fill_count), 0);

    // Asynchronous reset in the middle of a vector.
    drive(1'b1, 60, 1'b0, 1'b0, 1'b0);
    cyc("rst_w0");
    drive(1'b1, 64, 1'b0, 1'b0, 1'b0);
    cyc("rst_w1");
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    cyc("rst_r0");
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    #2 rst_in = 1'b0;
    #1;
    chk("async_reset:m_valid", int'(m_valid), 0);
    chk("async_reset:fill_count", int'(fill_count), 0);
    chk("async_reset:s_ready", int'(s_ready), 1);
    mq.delete();
    mbeat = 0;
    mdone = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    drive(1'b1, 200, 1'b0, 1'b0, 1'b0);
    cyc("post_rst_w");
    chk("post_rst:fill", int'(fill_count), 4);
    chk("post_rst:m_data[0]", int'(m_data[0]), 200);

    // Clear together with an accepted-looking write: the write is dropped.
    drive(1'b1, 210, 1'b0, 1'b0, 1'b1);
    cyc("clear");
    chk("clear:fill", int'(fill_count), 0);
    chk("clear:m_valid", int'(m_valid), 0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 220 + 4 * i, 1'b0, 1'b0, 1'b0);
      cyc("post_clear_w");
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cyc("post_clear_r");
    end
    chk("post_clear:fill", int'(fill_count), 0);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
